cache_mem_responder: RTL and testbench

//   Backing-memory responder for the direct-mapped cache: the memory end of the cache miss/write interface.

---
 rtl/cache_mem_if.sv | 26 ++
 rtl/cache_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_cache_mem_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_if.sv
// Request/response bus between the cache controller (master) and its
// backing-memory responder (slave). Valid/ready on both channels.
interface cache_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Backing-memory responder for the direct-mapped cache. Serves one read or
// write at a time from a word array after a fixed latency, then holds the
// response until the consumer takes it.
// Optional build macro CACHE_MEM_STATS_EN adds saturating rd_count/wr_count
// outputs counting committed, non-error reads and writes.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUSY  | request captured, latency counter running down to zero
// RESP  | response presented, held until rsp_ready
module cache_mem_responder #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          RD_LAT     = 4,
  parameter int          WR_LAT     = 2,
  parameter logic [31:0] INIT_WORD  = 32'hABADDEED
) (
  input  logic          clk,
  input  logic          rst,
  cache_mem_if.slave    bus
`ifdef CACHE_MEM_STATS_EN
  ,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Counter loads LAT-1 so the terminal-count edge lands exactly LAT edges
  // after acceptance.
  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_we;
  logic              addr_err;
  logic [DEPTH_LOG2-1:0] idx;

`ifdef CACHE_MEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
`endif

  // Power-up array contents; reset never touches the array.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = INIT_WORD;
  end

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    (addr_q[ADDR_W-1:DEPTH_LOG2+2] != '0);

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  // Next-state, capture, latency countdown and response generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
`ifdef CACHE_MEM_STATS_EN
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          rw_d    = bus.req_rw;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = bus.req_rw ? WR_LOAD : RD_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          rsp_data_d  = (rw_q || addr_err) ? '0 : mem_q[idx];
          mem_we      = rw_q && !addr_err;
`ifdef CACHE_MEM_STATS_EN
          if (!addr_err && !rw_q && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
          if (!addr_err &&  rw_q && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array write at the commit edge; a reset on that edge discards the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[idx] <= wdata_q;
  end

`ifdef CACHE_MEM_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder (RD_LAT=4, WR_LAT=2, 1024 words).
// Define CACHE_MEM_STATS_EN for both bench and RTL to exercise the counters.
module tb_cache_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  cache_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_MEM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  cache_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef CACHE_MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after the accepting edge.
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    int waited = 0;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && waited < 30) begin
      step();
      waited++;
    end
    if (!bus.req_ready) begin
      $display("FAIL issue_timeout: req_ready stayed %b, wanted 1", bus.req_ready);
      n_checks++;
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  // Counts edges from acceptance to rsp_valid, samples, then handshakes.
  task automatic wait_rsp(output int lat, output logic [31:0] data, output logic err);
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin
      step();
      lat++;
    end
    data = bus.rsp_data;
    err  = bus.rsp_err;
    if (bus.rsp_valid) begin
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_data !== 32'h0) $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); else n_pass++;
  endtask

  task automatic test_read_init();
    int lat; logic [31:0] d; logic e;
    issue(1'b0, 32'h0, 32'h0);
    wait_rsp(lat, d, e);
    n_checks++; if (lat !== 4) $display("FAIL rd_init_lat: got %0d want 4", lat); else n_pass++;
    n_checks++; if (d !== 32'hABADDEED) $display("FAIL rd_init_data: got %h want abaddeed", d); else n_pass++;
    n_checks++; if (e !== 1'b0) $display("FAIL rd_init_err: got %b want 0", e); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] d; logic e;
    issue(1'b1, 32'h10, 32'hCAFEBABE);
    wait_rsp(lat, d, e);
    n_checks++; if (lat !== 2) $display("FAIL wr_lat: got %0d want 2", lat); else n_pass++;
    n_checks++; if (d !== 32'h0) $display("FAIL wr_data: got %h want 0", d); else n_pass++;
    n_checks++; if (e !== 1'b0) $display("FAIL wr_err: got %b want 0", e); else n_pass++;
    issue(1'b0, 32'h10, 32'h0);
    wait_rsp(lat, d, e);
    n_checks++; if (lat !== 4) $display("FAIL raw_lat: got %0d want 4", lat); else n_pass++;
    n_checks++; if (d !== 32'hCAFEBABE) $display("FAIL raw_data: got %h want cafebabe", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e;
    issue(1'b0, 32'h10, 32'h0);
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin step(); lat++; end
    n_checks++; if (lat !== 4) $display("FAIL bp_lat: got %0d want 4", lat); else n_pass++;
    // Second request held while the first response is stalled.
    bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b want 1", i, bus.rsp_valid); else n_pass++;
      n_checks++; if (bus.rsp_data !== 32'hCAFEBABE) $display("FAIL bp_data_%0d: got %h want cafebabe", i, bus.rsp_data); else n_pass++;
      n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL bp_ready_%0d: got %b want 0", i, bus.req_ready); else n_pass++;
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_hs_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL bp_hs_ready: got %b want 1", bus.req_ready); else n_pass++;
    step();
    bus.req_valid = 1'b0;
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL bp_second_accept: req_ready got %b want 0", bus.req_ready); else n_pass++;
    wait_rsp(lat, d, e);
    n_checks++; if (lat !== 4) $display("FAIL bp2_lat: got %0d want 4", lat); else n_pass++;
    n_checks++; if (d !== 32'hABADDEED) $display("FAIL bp2_data: got %h want abaddeed", d); else n_pass++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] d; logic e;
    logic [31:0] err_addr [4] = '{32'h1000, 32'h2, 32'h1000, 32'h12};
    logic        err_rw   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          exp_lat  [4] = '{4, 4, 2, 2};
    for (int i = 0; i < 4; i++) begin
      issue(err_rw[i], err_addr[i], 32'h5555AAAA);
      wait_rsp(lat, d, e);
      n_checks++; if (lat !== exp_lat[i]) $display("FAIL err%0d_lat: got %0d want %0d", i, lat, exp_lat[i]); else n_pass++;
      n_checks++; if (e !== 1'b1) $display("FAIL err%0d_err: got %b want 1", i, e); else n_pass++;
      n_checks++; if (d !== 32'h0) $display("FAIL err%0d_data: got %h want 0", i, d); else n_pass++;
    end
    issue(1'b0, 32'h0, 32'h0);
    wait_rsp(lat, d, e);
    n_checks++; if (d !== 32'hABADDEED) $display("FAIL err_unchanged_0: got %h want abaddeed", d); else n_pass++;
    issue(1'b0, 32'h10, 32'h0);
    wait_rsp(lat, d, e);
    n_checks++; if (d !== 32'hCAFEBABE) $display("FAIL err_unchanged_10: got %h want cafebabe", d); else n_pass++;
  endtask

  task automatic test_reset_busy();
    int lat; logic [31:0] d; logic e; int seen = 0;
    issue(1'b1, 32'h20, 32'h12345678);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rstbusy_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rstbusy_ready: got %b want 1", bus.req_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.rsp_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rstbusy_no_rsp: valid cycles got %0d want 0", seen); else n_pass++;
    issue(1'b0, 32'h20, 32'h0);
    wait_rsp(lat, d, e);
    n_checks++; if (d !== 32'hABADDEED) $display("FAIL rstbusy_data: got %h want abaddeed", d); else n_pass++;
  endtask

`ifdef CACHE_MEM_STATS_EN
  task automatic test_stats();
    int lat; logic [31:0] d; logic e;
    do_reset(1);
    issue(1'b0, 32'h0, 32'h0);        wait_rsp(lat, d, e);
    issue(1'b1, 32'h40, 32'h1);       wait_rsp(lat, d, e);
    issue(1'b0, 32'h4, 32'h0);        wait_rsp(lat, d, e);
    issue(1'b0, 32'h1003, 32'h0);     wait_rsp(lat, d, e);
    issue(1'b1, 32'h44, 32'h2);       wait_rsp(lat, d, e);
    issue(1'b0, 32'h8, 32'h0);        wait_rsp(lat, d, e);
    n_checks++; if (rd_count !== 16'd3) $display("FAIL stats_rd: got %0d want 3", rd_count); else n_pass++;
    n_checks++; if (wr_count !== 16'd2) $display("FAIL stats_wr: got %0d want 2", wr_count); else n_pass++;
    do_reset(1);
    n_checks++; if (rd_count !== 16'd0) $display("FAIL stats_rd_rst: got %0d want 0", rd_count); else n_pass++;
    n_checks++; if (wr_count !== 16'd0) $display("FAIL stats_wr_rst: got %0d want 0", wr_count); else n_pass++;
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    #1;
    test_reset();
    test_read_init();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_reset_busy();
`ifdef CACHE_MEM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
